// File: rtl/mux4_sel_pkg.sv
// Shared types and constants for the mux4 select arbiter.
// State encodings, channel/select widths and a one-hot helper.
package mux4_sel_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [NUM_CH-1:0] onehot4(
    input logic [SEL_W-1:0] idx
  );
    onehot4 = NUM_CH'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick over four requests.
// Scans ptr, ptr+1, .. (mod 4) and reports the first set bit.
import mux4_sel_pkg::*;

module rr_pick4 (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  idx,
  output logic              any
);

  always_comb begin
    idx = '0;
    any = |req;
    // Walk from the farthest offset down so the nearest hit wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[ptr + SEL_W'(k)]) begin
        idx = ptr + SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux4_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit sel of a 4:1 mux stage.
// MUX4_SEL_PARK_EN: keep the last granted sel through GAP and IDLE.
import mux4_sel_pkg::*;

module mux4_sel_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              done,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] grant,
  output logic              busy,
  output logic              grant_start
);

  localparam logic [CNT_W-1:0] LP_CNT_INIT =
    CNT_W'(HOLD_CYCLES - 1);

  state_t             r_state;
  state_t             w_nx_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_nx_cnt;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   w_nx_ptr;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_nx_sel;
  logic [NUM_CH-1:0]  r_grant;
  logic [NUM_CH-1:0]  w_nx_grant;
  logic               r_busy;
  logic               w_nx_busy;
  logic               r_gstart;
  logic               w_nx_gstart;

  logic [SEL_W-1:0]   w_idx;
  logic               w_any;
  logic               w_exit;
  logic [SEL_W-1:0]   w_sel_rest;

  rr_pick4 u_pick (
    .req (req),
    .ptr (r_ptr),
    .idx (w_idx),
    .any (w_any)
  );

`ifdef MUX4_SEL_PARK_EN
  assign w_sel_rest = r_sel;
`else
  assign w_sel_rest = '0;
`endif

  // Coincident end conditions collapse into one exit.
  assign w_exit = (r_cnt == '0) | done | ~req[r_sel];

  always_comb begin
    w_nx_state  = r_state;
    w_nx_cnt    = r_cnt;
    w_nx_ptr    = r_ptr;
    w_nx_sel    = r_sel;
    w_nx_grant  = r_grant;
    w_nx_busy   = r_busy;
    w_nx_gstart = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_nx_sel   = w_sel_rest;
        w_nx_grant = '0;
        w_nx_busy  = 1'b0;
        if (w_any) begin
          w_nx_state  = ST_HOLD;
          w_nx_grant  = onehot4(w_idx);
          w_nx_sel    = w_idx;
          w_nx_busy   = 1'b1;
          w_nx_gstart = 1'b1;
          w_nx_cnt    = LP_CNT_INIT;
        end
      end
      ST_HOLD: begin
        if (w_exit) begin
          w_nx_state = ST_GAP;
          w_nx_ptr   = r_sel + SEL_W'(1);
          w_nx_grant = '0;
          w_nx_busy  = 1'b0;
          w_nx_sel   = w_sel_rest;
        end else begin
          w_nx_cnt = r_cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        w_nx_state = ST_IDLE;
        w_nx_sel   = w_sel_rest;
        w_nx_grant = '0;
        w_nx_busy  = 1'b0;
      end
      default: begin
        w_nx_state = ST_IDLE;
        w_nx_cnt   = '0;
        w_nx_sel   = '0;
        w_nx_grant = '0;
        w_nx_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_sel    <= '0;
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_gstart <= 1'b0;
    end else begin
      r_state  <= w_nx_state;
      r_cnt    <= w_nx_cnt;
      r_ptr    <= w_nx_ptr;
      r_sel    <= w_nx_sel;
      r_grant  <= w_nx_grant;
      r_busy   <= w_nx_busy;
      r_gstart <= w_nx_gstart;
    end
  end

  assign sel         = r_sel;
  assign grant       = r_grant;
  assign busy        = r_busy;
  assign grant_start = r_gstart;

endmodule

// File: tb/tb_mux4_sel_arbiter.sv
// Directed bench for mux4_sel_arbiter (HOLD_CYCLES=4).
// Sel expectations in GAP/IDLE follow MUX4_SEL_PARK_EN.
module tb_mux4_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       busy;
  logic       grant_start;

  int checks   = 0;
  int failures = 0;

`ifdef MUX4_SEL_PARK_EN
  localparam logic [1:0] SEL_P2 = 2'd2;
  localparam logic [1:0] SEL_P3 = 2'd3;
`else
  localparam logic [1:0] SEL_P2 = 2'd0;
  localparam logic [1:0] SEL_P3 = 2'd0;
`endif

  mux4_sel_arbiter #(
    .HOLD_CYCLES (4),
    .CNT_W       (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .sel         (sel),
    .grant       (grant),
    .busy        (busy),
    .grant_start (grant_start)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel",   32'(sel),         32'd0);
    chk("rst_grant", 32'(grant),       32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_gs",    32'(grant_start), 32'd0);
    req   = 4'b0000;
    rst_n = 1'b1;

    // single requester ch2
    req = 4'b0100;
    step();
    chk("t2_grant", 32'(grant),       32'h4);
    chk("t2_sel",   32'(sel),         32'd2);
    chk("t2_gs",    32'(grant_start), 32'd1);
    chk("t2_busy1", 32'(busy),        32'd1);
    step();
    chk("t2_gs0",   32'(grant_start), 32'd0);
    chk("t2_busy2", 32'(busy),        32'd1);
    step();
    step();
    chk("t2_busy4", 32'(busy),        32'd1);
    chk("t2_hold",  32'(grant),       32'h4);
    step();
    chk("t2_gap_busy",  32'(busy),  32'd0);
    chk("t2_gap_grant", 32'(grant), 32'd0);
    chk("t2_gap_sel",   32'(sel),   32'(SEL_P2));
    step();
    chk("t2_idle_busy", 32'(busy),        32'd0);
    chk("t2_idle_gs",   32'(grant_start), 32'd0);
    step();
    chk("t2_regrant",    32'(grant),       32'h4);
    chk("t2_regrant_gs", 32'(grant_start), 32'd1);
    req = 4'b0000;
    step();
    chk("t2_drop", 32'(busy), 32'd0);
    pulse_rst();

    // round robin with all requesting
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      logic [3:0] e;
      e = 4'(1 << (g % 4));
      step();
      chk("t3_grant", 32'(grant),       32'(e));
      chk("t3_gs",    32'(grant_start), 32'd1);
      step();
      step();
      step();
      chk("t3_busy4", 32'(busy),  32'd1);
      chk("t3_hold",  32'(grant), 32'(e));
      step();
      chk("t3_gap",   32'(busy),  32'd0);
      step();
      chk("t3_idle",  32'(grant), 32'd0);
    end
    req = 4'b0000;
    pulse_rst();

    // early end by done on 2nd HOLD cycle
    req = 4'b0010;
    step();
    chk("t4_grant", 32'(grant), 32'h2);
    step();
    done = 1'b1;
    step();
    chk("t4_done_gap", 32'(busy), 32'd0);
    done = 1'b0;
    step();
    step();
    chk("t4_grant2", 32'(grant), 32'h2);
    step();
    req = 4'b0000;
    step();
    chk("t4_drop_gap", 32'(busy), 32'd0);
    req = 4'b0010;
    step();
    chk("t4_idle", 32'(busy), 32'd0);
    step();
    chk("t4_grant3", 32'(grant), 32'h2);
    step();
    step();
    step();
    chk("t4_h4", 32'(busy), 32'd1);
    done = 1'b1;
    step();
    chk("t4_coinc_gap", 32'(busy), 32'd0);
    done = 1'b0;
    step();
    chk("t4_coinc_idle", 32'(busy),        32'd0);
    chk("t4_coinc_gs",   32'(grant_start), 32'd0);
    step();
    chk("t4_after", 32'(grant_start), 32'd1);
    req = 4'b0000;
    step();
    pulse_rst();

    // ch3 then wrap to ch0; sel parking
    req = 4'b1000;
    step();
    chk("t5_grant3", 32'(grant), 32'h8);
    chk("t5_sel3",   32'(sel),   32'd3);
    req = 4'b0000;
    step();
    chk("t5_gap_sel", 32'(sel),  32'(SEL_P3));
    chk("t5_gap",     32'(busy), 32'd0);
    req = 4'b1001;
    step();
    chk("t5_idle_sel", 32'(sel), 32'(SEL_P3));
    step();
    chk("t5_wrap",     32'(grant), 32'h1);
    chk("t5_wrap_sel", 32'(sel),   32'd0);
    req = 4'b0000;
    step();
    step();
    req = 4'b0010;
    step();
    chk("t5_grant1", 32'(grant), 32'h2);
    step();
    rst_n = 1'b0;
    #1;
    chk("t5_rst_sel",   32'(sel),         32'd0);
    chk("t5_rst_grant", 32'(grant),       32'd0);
    chk("t5_rst_busy",  32'(busy),        32'd0);
    chk("t5_rst_gs",    32'(grant_start), 32'd0);
    req   = 4'b1111;
    rst_n = 1'b1;
    step();
    chk("t5_ptr0", 32'(grant), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
